// File: rtl/lu_mem_pkg.sv
// lu_mem_pkg: shared widths and sequencer state encoding for the LU memory path
package lu_mem_pkg;
  localparam int DTU_DDR_W  = 24;
  localparam int DTU_RAM_W  = 7;
  localparam int DTU_SIZE_W = 6;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_DRAIN, S_FIN} seq_state_t;
endpackage

// File: rtl/dtu_tile_sequencer.sv
// dtu_tile_sequencer: walks a 2-D tile as one DTU request per row, one outstanding at a time
module dtu_tile_sequencer
  import lu_mem_pkg::*;
#(
  parameter int DDRSIZEWIDTH = DTU_DDR_W,
  parameter int RAMSIZEWIDTH = DTU_RAM_W,
  parameter int ROWWIDTH     = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [DDRSIZEWIDTH-1:0] req_mem_addr,
  input  logic [RAMSIZEWIDTH-1:0] req_ram_addr,
  input  logic [ROWWIDTH-1:0]     req_rows,
  input  logic [DTU_SIZE_W-1:0]   req_size,
  input  logic [DDRSIZEWIDTH-1:0] req_mem_stride,
  input  logic [RAMSIZEWIDTH-1:0] req_ram_stride,
  output logic                    busy,
  output logic                    done,
  output logic                    dtu_write_req,
  output logic                    dtu_read_req,
  output logic [DDRSIZEWIDTH-1:0] dtu_mem_addr,
  output logic [RAMSIZEWIDTH-1:0] dtu_ram_addr,
  output logic [DTU_SIZE_W-1:0]   dtu_size,
  input  logic                    dtu_ack,
  input  logic                    dtu_done
);
  seq_state_t              r_state;
  logic                    r_write;
  logic [DDRSIZEWIDTH-1:0] r_mem_addr, r_mem_stride;
  logic [RAMSIZEWIDTH-1:0] r_ram_addr, r_ram_stride;
  logic [DTU_SIZE_W-1:0]   r_size;
  logic [ROWWIDTH-1:0]     r_rows_left;
  assign dtu_mem_addr = r_mem_addr;
  assign dtu_ram_addr = r_ram_addr;
  assign dtu_size     = r_size;
  // Sequencer FSM: working registers double as the registered DTU address/size outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      dtu_write_req <= 1'b0;
      dtu_read_req  <= 1'b0;
      r_write       <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_stride  <= '0;
      r_ram_addr    <= '0;
      r_ram_stride  <= '0;
      r_size        <= '0;
      r_rows_left   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_write      <= req_write;
          r_mem_addr   <= req_mem_addr;
          r_mem_stride <= req_mem_stride;
          r_ram_addr   <= req_ram_addr;
          r_ram_stride <= req_ram_stride;
          r_size       <= req_size;
          r_rows_left  <= req_rows;
          req_ready    <= 1'b0;
          busy         <= 1'b1;
          if (req_rows == '0) begin
            r_state <= S_FIN;
            done    <= 1'b1;
          end else begin
            r_state       <= S_ISSUE;
            dtu_write_req <= req_write;
            dtu_read_req  <= !req_write;
          end
        end
        S_ISSUE: if (dtu_ack) begin
          dtu_write_req <= 1'b0;
          dtu_read_req  <= 1'b0;
          r_mem_addr    <= r_mem_addr + r_mem_stride;
          r_ram_addr    <= r_ram_addr + r_ram_stride;
          r_rows_left   <= r_rows_left - 1'b1;
          r_state       <= S_WAIT_ACK;
        end
        S_WAIT_ACK: if (dtu_ack) begin
          if (r_rows_left != '0) begin
            r_state       <= S_ISSUE;
            dtu_write_req <= r_write;
            dtu_read_req  <= !r_write;
          end else begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: if (dtu_done) begin
          r_state <= S_FIN;
          done    <= 1'b1;
        end
        S_FIN: begin
          r_state   <= S_IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dtu_tile_sequencer.sv
// tb_dtu_tile_sequencer: table, random and corner-case checks against a row-list model
module tb_dtu_tile_sequencer;
  logic        clk = 0, reset = 1;
  logic        req_valid = 0, req_write = 0;
  logic [23:0] req_mem_addr = 0, req_mem_stride = 0;
  logic [6:0]  req_ram_addr = 0, req_ram_stride = 0;
  logic [5:0]  req_rows = 0, req_size = 0;
  logic        req_ready, busy, done, dtu_write_req, dtu_read_req, dtu_ack, dtu_done;
  logic [23:0] dtu_mem_addr;
  logic [6:0]  dtu_ram_addr;
  logic [5:0]  dtu_size;
  int errors = 0, checks = 0;

  dtu_tile_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_mem_addr(req_mem_addr), .req_ram_addr(req_ram_addr),
    .req_rows(req_rows), .req_size(req_size), .req_mem_stride(req_mem_stride),
    .req_ram_stride(req_ram_stride), .busy(busy), .done(done),
    .dtu_write_req(dtu_write_req), .dtu_read_req(dtu_read_req),
    .dtu_mem_addr(dtu_mem_addr), .dtu_ram_addr(dtu_ram_addr), .dtu_size(dtu_size),
    .dtu_ack(dtu_ack), .dtu_done(dtu_done)
  );

  always #5 clk = ~clk;

  // Simple DTU: idle (ack) unless busy for lat_cfg cycles after taking a request; FIFOs drain drain_cfg later
  int lat_cfg = 1, drain_cfg = 0, busy_c = 0, drain_c = 0;
  bit hold_ack = 0;
  assign dtu_ack  = (busy_c == 0) && !hold_ack;
  assign dtu_done = dtu_ack && (drain_c == 0);
  always @(posedge clk) begin
    if (reset) begin
      busy_c  <= 0;
      drain_c <= 0;
    end else if ((dtu_write_req || dtu_read_req) && dtu_ack) begin
      busy_c  <= lat_cfg;
      drain_c <= lat_cfg + drain_cfg;
    end else begin
      if (busy_c > 0) busy_c <= busy_c - 1;
      if (drain_c > 0) drain_c <= drain_c - 1;
    end
  end

  // Observed rows (each accepted strobe) and done pulses
  typedef struct { bit w; logic [23:0] mem; logic [6:0] ram; logic [5:0] size; } row_t;
  row_t obs[$];
  int n_done = 0;
  always @(posedge clk) begin
    if (!reset && (dtu_write_req || dtu_read_req) && dtu_ack)
      obs.push_back('{dtu_write_req, dtu_mem_addr, dtu_ram_addr, dtu_size});
    if (!reset && done) n_done <= n_done + 1;
  end

  typedef struct {
    bit w; logic [23:0] mem; logic [6:0] ram; logic [5:0] rows; logic [5:0] size;
    logic [23:0] ms; logic [6:0] rs; int lat; int drain;
    int exp_n; logic [23:0] exp_mem; logic [6:0] exp_ram;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (dtu_write_req || dtu_read_req) chk("strobe_legal", {30'd0, dtu_write_req && dtu_read_req, !busy}, 0);
  endtask

  task automatic drive(input vec_t v);
    req_write = v.w; req_mem_addr = v.mem; req_ram_addr = v.ram; req_rows = v.rows;
    req_size = v.size; req_mem_stride = v.ms; req_ram_stride = v.rs;
    lat_cfg = v.lat; drain_cfg = v.drain;
  endtask

  // Issues one command (optionally with a busy-time command that must be ignored) and checks every row
  task automatic run_cmd(input vec_t v, input bit noise);
    int base, d0, k;
    logic pd;
    pd = 0;
    chk("ready_before", req_ready, 1);
    base = obs.size(); d0 = n_done;
    drive(v);
    req_valid = 1;
    tick();
    req_valid = 0;
    if (v.rows == 0) begin
      chk("zero_done_t1", done, 1);
      chk("zero_ready_t1", req_ready, 0);
    end else begin
      chk("first_strobe", dtu_write_req | dtu_read_req, 1);
      chk("strobe_dir", dtu_write_req, v.w);
    end
    k = 0;
    while (!done && k < 3000) begin
      req_valid = noise && k < 2;
      req_mem_addr = ~v.mem;
      req_rows = 6'd9;
      pd = dtu_done;
      tick();
      k++;
    end
    req_valid = 0;
    chk("done_seen", done, 1);
    if (v.rows != 0) chk("done_after_dtu_done", pd, 1);
    tick();
    chk("done_count", n_done - d0, 1);
    chk("ready_after_done", req_ready, 1);
    chk("row_count", obs.size() - base, v.rows);
    for (int i = 0; i < int'(v.rows) && base + i < obs.size(); i++) begin
      chk("row_mem", obs[base+i].mem, 24'(v.mem + 24'(i) * v.ms));
      chk("row_ram", obs[base+i].ram, 7'(v.ram + 7'(i) * v.rs));
      chk("row_dir", obs[base+i].w, v.w);
      chk("row_size", obs[base+i].size, v.size);
    end
    if (v.exp_n > 0 && obs.size() >= base + v.exp_n) begin
      chk("last_mem", obs[base+v.exp_n-1].mem, v.exp_mem);
      chk("last_ram", obs[base+v.exp_n-1].ram, v.exp_ram);
    end
  endtask

  initial begin
    vec_t v;
    int base, d0, k;
    tbl.push_back('{1'b1, 24'h100, 7'd5, 6'd3, 6'd4, 24'h40, 7'd8, 6, 2, 3, 24'h180, 7'd21});
    tbl.push_back('{1'b0, 24'h55, 7'd9, 6'd0, 6'd3, 24'h10, 7'd1, 1, 0, 0, 24'h0, 7'd0});
    tbl.push_back('{1'b0, 24'hFFFFC0, 7'd120, 6'd2, 6'd7, 24'h40, 7'd8, 2, 1, 2, 24'h0, 7'd0});
    tbl.push_back('{1'b0, 24'h1234, 7'd3, 6'd1, 6'd0, 24'h7, 7'd1, 1, 0, 1, 24'h1234, 7'd3});
    tbl.push_back('{1'b1, 24'h0, 7'd0, 6'd63, 6'd63, 24'h1, 7'd2, 1, 0, 63, 24'h3E, 7'd124});
    tick(); tick();
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_strobes", {dtu_write_req, dtu_read_req}, 0);
    chk("rst_addr", {dtu_mem_addr, dtu_ram_addr, dtu_size}, 0);
    reset = 0;
    tick();
    foreach (tbl[i]) run_cmd(tbl[i], 1'b0);

    // ack held low while the strobe waits: request stays put and is consumed once
    v = '{1'b1, 24'hABC, 7'd17, 6'd1, 6'd5, 24'h1, 7'd1, 2, 1, 1, 24'hABC, 7'd17};
    base = obs.size(); d0 = n_done;
    hold_ack = 1;
    drive(v);
    req_valid = 1;
    tick();
    req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("hold_strobe", dtu_write_req, 1);
      chk("hold_addr", dtu_mem_addr, 24'hABC);
      chk("hold_none_taken", obs.size() - base, 0);
      if (i < 3) tick();
    end
    hold_ack = 0;
    tick();
    chk("hold_dropped", dtu_write_req, 0);
    chk("hold_taken_once", obs.size() - base, 1);
    k = 0;
    while (!done && k < 100) begin tick(); k++; end
    chk("hold_done", done, 1);
    tick();
    chk("hold_no_dup", obs.size() - base, 1);
    chk("hold_done_cnt", n_done - d0, 1);

    // reset in WAIT_ACK of row 2 of 4
    v = '{1'b0, 24'h2000, 7'd40, 6'd4, 6'd9, 24'h100, 7'd4, 5, 1, 4, 24'h2300, 7'd52};
    base = obs.size();
    drive(v);
    req_valid = 1;
    tick();
    req_valid = 0;
    k = 0;
    while (obs.size() - base < 2 && k < 200) begin tick(); k++; end
    chk("rst_mid_rows_seen", obs.size() - base, 2);
    chk("rst_mid_waiting", busy && !dtu_write_req && !dtu_read_req, 1);
    reset = 1;
    tick();
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_strobes", {dtu_write_req, dtu_read_req}, 0);
    chk("rst_mid_addr", {dtu_mem_addr, dtu_ram_addr, dtu_size}, 0);
    reset = 0;
    d0 = n_done; base = obs.size();
    for (int i = 0; i < 10; i++) tick();
    chk("rst_mid_no_done", n_done - d0, 0);
    chk("rst_mid_no_rows", obs.size() - base, 0);
    run_cmd(tbl[0], 1'b0);

    // back-to-back commands, with a second command offered while busy
    v = '{1'b1, 24'h800, 7'd2, 6'd2, 6'd11, 24'h20, 7'd3, 4, 0, 2, 24'h820, 7'd5};
    run_cmd(v, 1'b1);
    run_cmd(tbl[2], 1'b0);

    // random commands against the row-list model
    for (int n = 0; n < 25; n++) begin
      v.w = 1'($urandom);
      v.mem = 24'($urandom);
      v.ram = 7'($urandom);
      v.rows = 6'($urandom_range(0, 6));
      v.size = 6'($urandom);
      v.ms = 24'($urandom);
      v.rs = 7'($urandom);
      v.lat = $urandom_range(1, 4);
      v.drain = $urandom_range(0, 3);
      v.exp_n = int'(v.rows);
      v.exp_mem = 24'(v.mem + (24'(v.rows) - 24'd1) * v.ms);
      v.exp_ram = 7'(v.ram + (7'(v.rows) - 7'd1) * v.rs);
      run_cmd(v, n % 5 == 0 && v.rows != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
